// File: rtl/shift_mul.sv
// Sequential shift-and-add multiplier (signed/unsigned) built on two shift instances.
// One n-iteration pass per op with a start/busy/done handshake; product held until the next completion.

module shift #(
    parameter int width = 8
) (
    input  logic [width-1:0]        i_data,
    input  logic                    i_right_en,
    input  logic                    i_sign,
    input  logic [$clog2(width):0]  i_shift_n,
    output logic [width-1:0]        o_data
);

    always_comb begin
        o_data = i_data;
        if (i_right_en) begin
            if (i_sign) o_data = $signed(i_data) >>> i_shift_n;
            else        o_data = i_data >> i_shift_n;
        end else begin
            o_data = i_data << i_shift_n;
        end
    end

endmodule

module shift_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sign,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] product
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0]            CNT_LAST = CW'(n - 1);
    localparam logic [$clog2(2*n):0]     SH_W1    = 1;
    localparam logic [$clog2(n):0]       SH_N1    = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [2*n-1:0] r_mcand, r_acc, r_product;
    logic [n-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;

    logic [n-1:0]   w_abs_a, w_abs_b, w_mplier_sh;
    logic [2*n-1:0] w_mcand_sh, w_acc_next, w_prod_next;

    // Magnitudes are taken as n-bit unsigned, so -2^(n-1) maps cleanly to 2^(n-1).
    assign w_abs_a     = (sign && a[n-1]) ? (~a + 1'b1) : a;
    assign w_abs_b     = (sign && b[n-1]) ? (~b + 1'b1) : b;
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_next = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;

    shift #(.width(2*n)) u_shl (
        .i_data     (r_mcand),
        .i_right_en (1'b0),
        .i_sign     (1'b0),
        .i_shift_n  (SH_W1),
        .o_data     (w_mcand_sh)
    );

    shift #(.width(n)) u_shr (
        .i_data     (r_mplier),
        .i_right_en (1'b1),
        .i_sign     (1'b0),
        .i_shift_n  (SH_N1),
        .o_data     (w_mplier_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mcand  <= {{n{1'b0}}, w_abs_a};
                    r_mplier <= w_abs_b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_neg    <= sign & (a[n-1] ^ b[n-1]);
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= w_mcand_sh;
                    r_mplier <= w_mplier_sh;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_product <= w_prod_next;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule
